// File: rtl/mulxx_core.sv
// Registered signed/unsigned multiplier with arithmetic right shift of the product.
// Optional MULXX_ROUND_EN: round half up before the shift instead of flooring.
module mulxx_core #(
    parameter int WORD_SIZE = 18
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WORD_SIZE-1:0] r0,
    input  logic [WORD_SIZE-1:0] r1,
    input  logic [4:0]           shift,
    input  logic                 signx,
    input  logic                 signy,
    output logic [WORD_SIZE-1:0] res,
    output logic                 out_valid
);

    localparam int EXT_W = WORD_SIZE + 1;
    localparam int PROD_W = 2 * WORD_SIZE + 2;
    localparam logic [4:0] MAX_SHIFT = 5'd18;

    logic signed [EXT_W-1:0]  x_ext;
    logic signed [EXT_W-1:0]  y_ext;
    logic signed [PROD_W-1:0] x_wide;
    logic signed [PROD_W-1:0] y_wide;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] prod_adj;
    logic signed [PROD_W-1:0] shifted;
    logic [4:0]               shift_eff;

    logic [WORD_SIZE-1:0] res_d;
    logic [WORD_SIZE-1:0] res_q;
    logic                 out_valid_d;
    logic                 out_valid_q;

    always_comb begin
        // One extra bit lets unsigned operands live in a signed product.
        x_ext     = signx ? $signed({r0[WORD_SIZE-1], r0}) : $signed({1'b0, r0});
        y_ext     = signy ? $signed({r1[WORD_SIZE-1], r1}) : $signed({1'b0, r1});
        x_wide    = PROD_W'(x_ext);
        y_wide    = PROD_W'(y_ext);
        prod      = x_wide * y_wide;
        shift_eff = (shift > MAX_SHIFT) ? MAX_SHIFT : shift;
`ifdef MULXX_ROUND_EN
        if (shift_eff != 5'd0) begin
            prod_adj = prod + (PROD_W'(1) << (shift_eff - 5'd1));
        end else begin
            prod_adj = prod;
        end
`else
        prod_adj = prod;
`endif
        shifted = prod_adj >>> shift_eff;
    end

    always_comb begin
        res_d       = res_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            res_d       = shifted[WORD_SIZE-1:0];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign res       = res_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mulxx_core.sv
// Directed and random checks of mulxx_core against an arithmetic reference model.
module tb_mulxx_core;

    localparam int W = 18;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] r0;
    logic [W-1:0] r1;
    logic [4:0]   shift;
    logic         signx;
    logic         signy;
    logic [W-1:0] res;
    logic         out_valid;

    int compared;
    int mismatched;

    mulxx_core #(.WORD_SIZE(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .r0        (r0),
        .r1        (r1),
        .shift     (shift),
        .signx     (signx),
        .signy     (signy),
        .res       (res),
        .out_valid (out_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [4:0] sh, input logic sx, input logic sy);
        longint x;
        longint y;
        longint p;
        int     s;
        x = sx ? longint'($signed(a)) : longint'(a);
        y = sy ? longint'($signed(b)) : longint'(b);
        p = x * y;
        s = (sh > 5'd18) ? 18 : int'(sh);
`ifdef MULXX_ROUND_EN
        if (s > 0) p = p + (longint'(1) <<< (s - 1));
`endif
        p = p >>> s;
        return p[W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] sh,
                      input logic sx, input logic sy);
        r0 = a; r1 = b; shift = sh; signx = sx; signy = sy; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        $display("op r0=0x%05h r1=0x%05h shift=%0d sx=%0b sy=%0b -> res=0x%05h out_valid=%0b",
                 a, b, sh, sx, sy, res, out_valid);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [4:0]   sh;
        logic         sx;
        logic         sy;
        logic [W-1:0] held;
        compared = 0;
        mismatched = 0;
        reset = 1'b1; in_valid = 1'b0; r0 = '0; r1 = '0; shift = '0; signx = 0; signy = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_res", 32'(res), 32'h0);
        chk("reset_valid", 32'(out_valid), 32'h0);
        reset = 1'b0;

        op(18'd2, 18'd3, 5'd0, 1'b0, 1'b0);
        chk("basic_res", 32'(res), 32'd6);
        chk("basic_valid", 32'(out_valid), 32'd1);

        op(18'h3fffe, 18'd3, 5'd0, 1'b1, 1'b0);
        chk("neg2x3", 32'(res), 32'h3fffa);
        op(18'h3ffff, 18'h3ffff, 5'd0, 1'b1, 1'b1);
        chk("neg1xneg1", 32'(res), 32'd1);

        for (int s = 0; s < 8; s++) begin
            logic [W-1:0] full;
            full = 18'h3ffff;
            op(18'h3ffff, 18'd1, 5'(s), 1'b0, 1'b0);
            chk($sformatf("sweep_s%0d", s), 32'(res), 32'(full >> s));
        end
        op(18'h3ffff, 18'd37, 5'd10, 1'b0, 1'b0);
        chk("x37_s10", 32'(res), 32'h24ff);

        op(18'd4727, 18'd56782, 5'd10, 1'b0, 1'b0);
        chk("big_s10", 32'(res), 32'h3ffe5);
        op(18'd4727, 18'd56782, 5'd16, 1'b0, 1'b0);
        chk("big_s16", 32'(res), 32'hfff);
        op(18'd47273, 18'd56782, 5'd18, 1'b0, 1'b0);
        chk("big_s18", 32'(res), 32'h27ff);

        op(18'h3ffff, 18'h3ffff, 5'd18, 1'b0, 1'b0);
        chk("max_s18", 32'(res), 32'h3fffe);
        op(18'h3ffff, 18'h3ffff, 5'd25, 1'b0, 1'b0);
        chk("max_s25_clamp", 32'(res), 32'h3fffe);

        // Hold: no new operands, result must stay while out_valid drops.
        held = res;
        r0 = 18'd123; r1 = 18'd456;
        @(posedge clock);
        #1;
        $display("hold -> res=0x%05h out_valid=%0b", res, out_valid);
        chk("hold_res", 32'(res), 32'(held));
        chk("hold_valid", 32'(out_valid), 32'h0);

        op(18'd3, 18'd1, 5'd1, 1'b0, 1'b0);
`ifdef MULXX_ROUND_EN
        chk("round_3x1_s1", 32'(res), 32'd2);
`else
        chk("round_3x1_s1", 32'(res), 32'd1);
`endif

        // Reset wins over a simultaneous valid operation.
        r0 = 18'd100; r1 = 18'd200; shift = 5'd0; signx = 0; signy = 0;
        in_valid = 1'b1; reset = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0; reset = 1'b0;
        $display("reset+valid -> res=0x%05h out_valid=%0b", res, out_valid);
        chk("rst_pri_res", 32'(res), 32'h0);
        chk("rst_pri_valid", 32'(out_valid), 32'h0);

        for (int i = 0; i < 60; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            sh = 5'($urandom_range(0, 31));
            sx = 1'($urandom);
            sy = 1'($urandom);
            op(a, b, sh, sx, sy);
            chk($sformatf("rand%0d_res", i), 32'(res), 32'(model(a, b, sh, sx, sy)));
            chk($sformatf("rand%0d_valid", i), 32'(out_valid), 32'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
